// File: rtl/axi_wr_slave_ctrl_if.sv
// AXI4 write-channel bundle (AW/W/B) between a write master and axi_wr_slave_ctrl.
interface axi_wr_slave_ctrl_if #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 8
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic [ID_WIDTH-1:0]   awid;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [LEN_WIDTH-1:0]  awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
    logic                  awvalid;
    logic                  awready;
    logic [ID_WIDTH-1:0]   wid;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wlast;
    logic                  wvalid;
    logic                  wready;
    logic [ID_WIDTH-1:0]   bid;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        input  wid, wdata, wstrb, wlast, wvalid,
        input  bready,
        output awready, wready, bid, bresp, bvalid
    );

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        output wid, wdata, wstrb, wlast, wvalid,
        output bready,
        input  awready, wready, bid, bresp, bvalid
    );
endinterface

// File: rtl/axi_wr_slave_ctrl.sv
// AXI4 write slave: one burst at a time, decodes FIXED/INCR/WRAP into SRAM word writes,
// flags protocol/command errors as SLVERR and returns one B response per burst.
module axi_wr_slave_ctrl #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int LEN_WIDTH  = 8,
    parameter int MEM_AW     = 10
) (
    input  logic                   AXI_ACLK,
    input  logic                   AXI_ARESETn,
    axi_wr_slave_ctrl_if.slave     axi,
    output logic                   MEM_WE,
    output logic [MEM_AW-1:0]      MEM_ADDR,
    output logic [DATA_WIDTH-1:0]  MEM_WDATA,
    output logic [STRB_WIDTH-1:0]  MEM_WSTRB
);
    localparam int LG = $clog2(STRB_WIDTH);

    typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;
    state_t state, state_n;

    logic [ID_WIDTH-1:0]   id_q;
    logic [ADDR_WIDTH-1:0] addr_q, addr_n, step, bnd;
    logic [LEN_WIDTH-1:0]  len_q, cnt_q;
    logic [2:0]            size_q;
    logic [1:0]            burst_q;
    logic                  err_q, err_n, cmd_err;
    logic                  aw_hs, w_hs, b_hs, last_beat;

    assign aw_hs     = axi.awvalid & axi.awready;
    assign w_hs      = axi.wvalid & axi.wready;
    assign b_hs      = axi.bvalid & axi.bready;
    assign last_beat = (cnt_q == len_q);

    always_comb begin
        cmd_err = 1'b0;
        if (axi.awburst == 2'b11) cmd_err = 1'b1;
        if (axi.awsize > 3'(LG)) cmd_err = 1'b1;
        if (axi.awburst == 2'b10 &&
            !(axi.awlen == LEN_WIDTH'(1) || axi.awlen == LEN_WIDTH'(3) ||
              axi.awlen == LEN_WIDTH'(7) || axi.awlen == LEN_WIDTH'(15)))
            cmd_err = 1'b1;
    end

    // Next beat address; INCR realigns to the beat size after the first beat.
    always_comb begin
        step   = ADDR_WIDTH'(1) << size_q;
        bnd    = (ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) << size_q;
        addr_n = addr_q;
        case (burst_q)
            2'b01:   addr_n = (addr_q & ~(step - ADDR_WIDTH'(1))) + step;
            2'b10:   addr_n = (addr_q & ~(bnd - ADDR_WIDTH'(1))) |
                              ((addr_q + step) & (bnd - ADDR_WIDTH'(1)));
            default: addr_n = addr_q;
        endcase
    end

    // Error is sticky; a bad WID/WLAST beat is still written, later beats are not.
    assign err_n = err_q | (axi.wid != id_q) | (axi.wlast != last_beat);

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (aw_hs) state_n = DATA;
            DATA:    if (w_hs && last_beat) state_n = RESP;
            RESP:    if (b_hs) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge AXI_ACLK or negedge AXI_ARESETn) begin
        if (!AXI_ARESETn) begin
            state       <= IDLE;
            axi.awready <= 1'b0;
            axi.wready  <= 1'b0;
            axi.bvalid  <= 1'b0;
            axi.bid     <= '0;
            axi.bresp   <= 2'b00;
            id_q        <= '0;
            addr_q      <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            size_q      <= '0;
            burst_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state       <= state_n;
            axi.awready <= (state_n == IDLE);
            axi.wready  <= (state_n == DATA);
            axi.bvalid  <= (state_n == RESP);
            if (aw_hs) begin
                id_q    <= axi.awid;
                addr_q  <= axi.awaddr;
                len_q   <= axi.awlen;
                size_q  <= axi.awsize;
                burst_q <= axi.awburst;
                cnt_q   <= '0;
                err_q   <= cmd_err;
            end
            if (w_hs) begin
                err_q  <= err_n;
                cnt_q  <= cnt_q + LEN_WIDTH'(1);
                addr_q <= addr_n;
                if (last_beat) begin
                    axi.bid   <= id_q;
                    axi.bresp <= err_n ? 2'b10 : 2'b00;
                end
            end
        end
    end

    assign MEM_WE    = w_hs & ~err_q;
    assign MEM_ADDR  = addr_q[MEM_AW+LG-1:LG];
    assign MEM_WDATA = axi.wdata;
    assign MEM_WSTRB = axi.wstrb;
endmodule

// File: tb/tb_axi_wr_slave_ctrl.sv
// Directed bench for axi_wr_slave_ctrl: burst-level reference model checked every cycle,
// plus literal address/response expectations per scenario.
module tb_axi_wr_slave_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;

    int n_chk = 0;
    int n_fail = 0;

    axi_wr_slave_ctrl_if #(.ID_WIDTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .LEN_WIDTH(8)) ifc ();

    axi_wr_slave_ctrl #(.ID_WIDTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .STRB_WIDTH(4),
                        .LEN_WIDTH(8), .MEM_AW(10)) dut (
        .AXI_ACLK(clk), .AXI_ARESETn(rst_n), .axi(ifc),
        .MEM_WE(mem_we), .MEM_ADDR(mem_addr), .MEM_WDATA(mem_wdata), .MEM_WSTRB(mem_wstrb)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Closed-form byte address of beat i of a burst.
    function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [7:0] len,
                                              input logic [2:0] sz, input logic [1:0] bt, input int i);
        logic [31:0] n, bnd, base;
        n   = 32'd1 << sz;
        bnd = ({24'd0, len} + 32'd1) * n;
        base = a & ~(bnd - 32'd1);
        case (bt)
            2'b01:   return (i == 0) ? a : (a & ~(n - 32'd1)) + 32'(i) * n;
            2'b10:   return base + ((a - base + 32'(i) * n) % bnd);
            default: return a;
        endcase
    endfunction

    function automatic logic cmd_bad(input logic [7:0] len, input logic [2:0] sz, input logic [1:0] bt);
        return (bt == 2'b11) || (sz > 3'd2) ||
               (bt == 2'b10 && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15));
    endfunction

    typedef enum {M_IDLE, M_DATA, M_RESP} mph_t;
    mph_t        mph = M_IDLE;
    logic [3:0]  m_id;
    logic [31:0] m_addr;
    logic [7:0]  m_len;
    logic [2:0]  m_sz;
    logic [1:0]  m_bt;
    logic        m_err = 1'b0;
    logic [1:0]  m_bresp;
    int          m_cnt = 0;
    logic [9:0]  wr_log[$];
    logic [31:0] wd_log[$];
    logic [5:0]  b_log[$];

    always @(negedge clk) begin : cmp
        logic        exp_we;
        logic [31:0] ba;
        if (!rst_n) begin
            chk("rst_awready", ifc.awready, 0);
            chk("rst_wready", ifc.wready, 0);
            chk("rst_bvalid", ifc.bvalid, 0);
            chk("rst_mem_we", mem_we, 0);
            chk("rst_bid_bresp", {ifc.bid, ifc.bresp}, 0);
            mph = M_IDLE; m_err = 1'b0; m_cnt = 0;
        end else begin
            chk("awready", ifc.awready, mph == M_IDLE);
            chk("wready", ifc.wready, mph == M_DATA);
            chk("bvalid", ifc.bvalid, mph == M_RESP);
            if (mph == M_RESP) begin
                chk("bid", ifc.bid, m_id);
                chk("bresp", ifc.bresp, m_bresp);
            end
            exp_we = (mph == M_DATA) && ifc.wvalid && !m_err;
            chk("mem_we", mem_we, exp_we);
            if (exp_we) begin
                ba = beat_addr(m_addr, m_len, m_sz, m_bt, m_cnt);
                chk("mem_addr", mem_addr, ba[11:2]);
                chk("mem_wdata", mem_wdata, ifc.wdata);
                chk("mem_wstrb", mem_wstrb, ifc.wstrb);
            end
            if (mem_we) begin
                wr_log.push_back(mem_addr);
                wd_log.push_back(mem_wdata);
            end
            case (mph)
                M_IDLE: if (ifc.awvalid) begin
                    m_id = ifc.awid; m_addr = ifc.awaddr; m_len = ifc.awlen;
                    m_sz = ifc.awsize; m_bt = ifc.awburst;
                    m_err = cmd_bad(ifc.awlen, ifc.awsize, ifc.awburst);
                    m_cnt = 0; mph = M_DATA;
                end
                M_DATA: if (ifc.wvalid) begin
                    if (ifc.wid != m_id || ifc.wlast != (m_cnt == int'(m_len))) m_err = 1'b1;
                    if (m_cnt == int'(m_len)) begin
                        m_bresp = m_err ? 2'b10 : 2'b00;
                        mph = M_RESP;
                    end
                    m_cnt++;
                end
                M_RESP: if (ifc.bready) begin
                    b_log.push_back({ifc.bid, ifc.bresp});
                    mph = M_IDLE;
                end
                default: mph = M_IDLE;
            endcase
        end
    end

    task automatic send_aw(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                           input logic [2:0] sz, input logic [1:0] bt);
        int t = 0;
        ifc.awid = id; ifc.awaddr = a; ifc.awlen = len; ifc.awsize = sz; ifc.awburst = bt;
        ifc.awvalid = 1'b1;
        do begin @(negedge clk); t++; end while (!ifc.awready && t < 100);
        chk("aw_accept", ifc.awready, 1);
        @(posedge clk); #1 ifc.awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [3:0] id, input logic [31:0] d, input logic l);
        int t = 0;
        ifc.wid = id; ifc.wdata = d; ifc.wstrb = 4'hF; ifc.wlast = l; ifc.wvalid = 1'b1;
        do begin @(negedge clk); t++; end while (!ifc.wready && t < 100);
        chk("w_accept", ifc.wready, 1);
        @(posedge clk); #1 ifc.wvalid = 1'b0; ifc.wlast = 1'b0;
    endtask

    task automatic recv_b(input int dly);
        int t = 0;
        repeat (dly) begin
            @(negedge clk);
            chk("b_hold_bvalid", ifc.bvalid, 1);
            chk("b_hold_awready", ifc.awready, 0);
        end
        @(posedge clk); #1 ifc.bready = 1'b1;
        do begin @(negedge clk); t++; end while (!ifc.bvalid && t < 100);
        chk("b_seen", ifc.bvalid, 1);
        @(posedge clk); #1 ifc.bready = 1'b0;
        chk("awready_after_b", ifc.awready, 1);
        chk("bvalid_after_b", ifc.bvalid, 0);
    endtask

    task automatic burst(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                         input logic [2:0] sz, input logic [1:0] bt, input int last_at,
                         input int bad_wid_at, input int gap, input int bdly, input logic [31:0] dbase);
        wr_log.delete(); wd_log.delete(); b_log.delete();
        send_aw(id, a, len, sz, bt);
        chk("wready_latency", ifc.wready, 1);
        for (int i = 0; i <= int'(len); i++) begin
            if (i > 0) repeat (gap) begin @(posedge clk); #1; end
            send_w((i == bad_wid_at) ? id ^ 4'h1 : id, dbase + 32'(i), i == last_at);
        end
        chk("bvalid_latency", ifc.bvalid, 1);
        chk("wready_drop", ifc.wready, 0);
        recv_b(bdly);
    endtask

    task automatic log_is(input string nm, input int n, input logic [9:0] a0, input logic [9:0] a1,
                          input logic [9:0] a2, input logic [9:0] a3, input logic [5:0] b);
        logic [3:0][9:0] e;
        e = {a3, a2, a1, a0};
        chk({nm, "_nwr"}, wr_log.size(), n);
        for (int i = 0; i < n && i < wr_log.size(); i++) chk({nm, "_addr"}, wr_log[i], e[i]);
        chk({nm, "_nb"}, b_log.size(), 1);
        if (b_log.size() > 0) chk({nm, "_b"}, b_log[0], b);
    endtask

    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        ifc.awvalid = 0; ifc.wvalid = 0; ifc.bready = 0; ifc.wlast = 0;
        ifc.awid = 0; ifc.awaddr = 0; ifc.awlen = 0; ifc.awsize = 0; ifc.awburst = 0;
        ifc.wid = 0; ifc.wdata = 0; ifc.wstrb = 0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("awready_boot", ifc.awready, 1);

        burst(4'd3, 32'h40, 8'd0, 3'd2, 2'b01, 0, -1, 0, 0, 32'hDEADBEEF);
        log_is("t1", 1, 10'h10, 0, 0, 0, {4'd3, 2'b00});
        if (wd_log.size() > 0) chk("t1_data", wd_log[0], 32'hDEADBEEF);

        burst(4'd4, 32'h10, 8'd3, 3'd2, 2'b01, 3, -1, 2, 0, 32'h100);
        log_is("t2", 4, 10'h4, 10'h5, 10'h6, 10'h7, {4'd4, 2'b00});

        burst(4'd5, 32'h38, 8'd3, 3'd2, 2'b10, 3, -1, 0, 0, 32'h200);
        log_is("t3_wrap", 4, 10'hE, 10'hF, 10'hC, 10'hD, {4'd5, 2'b00});
        burst(4'd6, 32'h20, 8'd3, 3'd2, 2'b00, 3, -1, 1, 0, 32'h300);
        log_is("t3_fixed", 4, 10'h8, 10'h8, 10'h8, 10'h8, {4'd6, 2'b00});

        burst(4'd7, 32'h80, 8'd3, 3'd2, 2'b01, 1, -1, 0, 0, 32'h400);
        log_is("t4_early_last", 2, 10'h20, 10'h21, 0, 0, {4'd7, 2'b10});
        burst(4'd8, 32'h80, 8'd1, 3'd2, 2'b11, 1, -1, 0, 0, 32'h500);
        log_is("t4_rsvd", 0, 0, 0, 0, 0, {4'd8, 2'b10});
        burst(4'd9, 32'hC0, 8'd3, 3'd2, 2'b01, 3, 2, 0, 0, 32'h600);
        log_is("bad_wid", 3, 10'h30, 10'h31, 10'h32, 0, {4'd9, 2'b10});
        burst(4'd10, 32'h0, 8'd2, 3'd2, 2'b10, 2, -1, 0, 0, 32'h700);
        log_is("wrap_len2", 0, 0, 0, 0, 0, {4'd10, 2'b10});
        burst(4'd11, 32'h0, 8'd0, 3'd3, 2'b01, 0, -1, 0, 0, 32'h800);
        log_is("big_size", 0, 0, 0, 0, 0, {4'd11, 2'b10});

        burst(4'd12, 32'h3FC, 8'd1, 3'd2, 2'b01, 1, -1, 0, 5, 32'h900);
        log_is("t5", 2, 10'hFF, 10'h100, 0, 0, {4'd12, 2'b00});

        // Reset in the middle of a len=7 burst.
        wr_log.delete();
        send_aw(4'd13, 32'h100, 8'd7, 3'd2, 2'b01);
        send_w(4'd13, 32'hA0, 1'b0);
        send_w(4'd13, 32'hA1, 1'b0);
        @(negedge clk); #1 rst_n = 1'b0;
        #1;
        chk("t6_awready", ifc.awready, 0);
        chk("t6_wready", ifc.wready, 0);
        chk("t6_bvalid", ifc.bvalid, 0);
        chk("t6_mem_we", mem_we, 0);
        chk("t6_mem_addr", mem_addr, 0);
        chk("t6_bid_bresp", {ifc.bid, ifc.bresp}, 0);
        chk("t6_nwr", wr_log.size(), 2);
        @(negedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("t6_awready_rel", ifc.awready, 1);
        burst(4'd14, 32'h8, 8'd1, 3'd2, 2'b01, 1, -1, 0, 0, 32'hB00);
        log_is("t6_after", 2, 10'h2, 10'h3, 0, 0, {4'd14, 2'b00});

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
